// File: rtl/adc0808_responder_pkg.sv
// Shared types and constants for the ADC0808 chip-side responder.
package adc0808_responder_pkg;

  localparam int unsigned NumCh = 8;
  localparam int unsigned DataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StConv,
    StDone
  } state_e;

endpackage

// File: rtl/adc0808_responder_sar.sv
// 8-bit successive-approximation engine: one bit decided every BIT_CYCLES clocks, MSB first.
module adc0808_responder_sar
  import adc0808_responder_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_go,
  input  logic [DataW-1:0] i_sample,
  output logic [DataW-1:0] o_result,
  output logic             o_done
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BIT_CYCLES - 1);

  logic [DataW-1:0] r_sample;
  logic [DataW-1:0] r_sar;
  logic [2:0]       r_bit;
  logic [CntW-1:0]  r_cnt;
  logic             r_run;

  logic [DataW-1:0] w_trial;
  logic [DataW-1:0] w_next;
  logic             w_decide;

  // Trial value for the current bit and the comparator decision.
  always_comb begin
    w_trial  = r_sar | (DataW'(1) << r_bit);
    w_next   = (w_trial <= r_sample) ? w_trial : r_sar;
    w_decide = r_run && (r_cnt == CntMax);
    o_result = w_next;
    o_done   = w_decide && (r_bit == 3'd0);
  end

  // SAR state: clear wins over go; the sample is frozen at go so later input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_sample <= '0;
      r_sar    <= '0;
      r_bit    <= 3'd7;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_go) begin
      r_sample <= i_sample;
      r_sar    <= '0;
      r_bit    <= 3'd7;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (w_decide) begin
        r_sar <= w_next;
        r_cnt <= '0;
        if (r_bit == 3'd0) begin
          r_run <= 1'b0;
        end else begin
          r_bit <= r_bit - 3'd1;
        end
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/adc0808_responder.sv
// Chip-side model of the ADC0808 handshake: synchronizers, edge detect, FSM, latches, eoc timing.
module adc0808_responder
  import adc0808_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BIT_CYCLES  = 8,
  parameter int unsigned EOC_DELAY   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_ale,
  input  logic                   i_start,
  input  logic                   i_oe,
  input  logic [2:0]             i_addr,
  input  logic [NumCh*DataW-1:0] i_ch_values,
  output logic                   o_eoc,
  output logic [DataW-1:0]       o_data_out,
  output logic                   o_data_oe,
  output logic                   o_busy
);

  localparam int unsigned DlyW = (EOC_DELAY > 1) ? $clog2(EOC_DELAY) : 1;
  localparam logic [DlyW-1:0] DlyLoad = DlyW'((EOC_DELAY > 0) ? EOC_DELAY - 1 : 0);

  // Bit 2 = ale, bit 1 = start, bit 0 = oe; index 0 is the first flop.
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic                        r_ale_q;
  logic                        r_start_q;

  state_e           r_state;
  logic             r_eoc;
  logic             r_busy;
  logic [2:0]       r_addr;
  logic [DataW-1:0] r_out;
  logic             r_dly_act;
  logic [DlyW-1:0]  r_dly_cnt;

  logic [2:0]       w_ctl;
  logic             w_ale_rise;
  logic             w_start_rise;
  logic             w_start_fall;
  logic [DataW-1:0] w_sample;
  logic             w_sar_go;
  logic [DataW-1:0] w_sar_result;
  logic             w_sar_done;

  // Control-input synchronizer chains.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], {i_ale, i_start, i_oe}};
    end
  end

  // Edge detection on synchronized controls plus channel mux and output drive.
  always_comb begin
    w_ctl        = r_sync[SYNC_STAGES-1];
    w_ale_rise   = w_ctl[2] & ~r_ale_q;
    w_start_rise = w_ctl[1] & ~r_start_q;
    w_start_fall = ~w_ctl[1] & r_start_q;
    w_sample     = i_ch_values[{r_addr, 3'b000} +: DataW];
    w_sar_go     = (r_state == StArm) && w_start_fall;
    o_eoc        = r_eoc;
    o_busy       = r_busy;
    o_data_oe    = w_ctl[0];
    o_data_out   = w_ctl[0] ? r_out : '0;
  end

  adc0808_responder_sar #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_sar (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_start_rise),
    .i_go    (w_sar_go),
    .i_sample(w_sample),
    .o_result(w_sar_result),
    .o_done  (w_sar_done)
  );

  // Handshake FSM with address/output latches and eoc delay; a start rise always restarts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ale_q   <= 1'b0;
      r_start_q <= 1'b0;
      r_state   <= StIdle;
      r_eoc     <= 1'b1;
      r_busy    <= 1'b0;
      r_addr    <= '0;
      r_out     <= '0;
      r_dly_act <= 1'b0;
      r_dly_cnt <= '0;
    end else begin
      r_ale_q   <= w_ctl[2];
      r_start_q <= w_ctl[1];
      // Busy is still low in the start-rise cycle, so a coincident ALE lands first.
      if (w_ale_rise && !r_busy) begin
        r_addr <= i_addr;
      end
      if (w_start_rise) begin
        r_state <= StArm;
        r_busy  <= 1'b1;
        if (EOC_DELAY == 0) begin
          r_eoc     <= 1'b0;
          r_dly_act <= 1'b0;
        end else begin
          r_dly_act <= 1'b1;
          r_dly_cnt <= DlyLoad;
        end
      end else begin
        if (r_dly_act) begin
          if (r_dly_cnt == '0) begin
            r_eoc     <= 1'b0;
            r_dly_act <= 1'b0;
          end else begin
            r_dly_cnt <= r_dly_cnt - DlyW'(1);
          end
        end
        unique case (r_state)
          StIdle: ;
          StArm: begin
            if (w_start_fall) begin
              r_state <= StConv;
            end
          end
          StConv: begin
            // Completion overrides any still-pending eoc-low event.
            if (w_sar_done) begin
              r_state   <= StDone;
              r_out     <= w_sar_result;
              r_eoc     <= 1'b1;
              r_busy    <= 1'b0;
              r_dly_act <= 1'b0;
            end
          end
          StDone: r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc0808_responder.sv
// Self-checking bench for adc0808_responder: directed handshake cases plus randomized conversions.
module tb_adc0808_responder;

  localparam int S  = 2;
  localparam int BC = 8;
  localparam int ED = 2;
  localparam int P  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ale;
  logic        start;
  logic        oe;
  logic [2:0]  addr;
  logic [63:0] ch_values;
  logic        eoc, busy, doe;
  logic [7:0]  dout;
  logic        eoc1, busy1, doe1;
  logic [7:0]  dout1;

  always #(P/2) clk = ~clk;

  adc0808_responder #(
    .SYNC_STAGES(S), .BIT_CYCLES(BC), .EOC_DELAY(ED)
  ) u_dut (
    .i_clk(clk), .i_reset(rst), .i_ale(ale), .i_start(start), .i_oe(oe), .i_addr(addr),
    .i_ch_values(ch_values), .o_eoc(eoc), .o_data_out(dout), .o_data_oe(doe), .o_busy(busy)
  );

  adc0808_responder #(
    .SYNC_STAGES(S), .BIT_CYCLES(1), .EOC_DELAY(ED)
  ) u_dut_fast (
    .i_clk(clk), .i_reset(rst), .i_ale(ale), .i_start(start), .i_oe(oe), .i_addr(addr),
    .i_ch_values(ch_values), .o_eoc(eoc1), .o_data_out(dout1), .o_data_oe(doe1),
    .o_busy(busy1)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] m_ch[8];
  logic [2:0] m_addr;
  bit         m_busy;
  logic [7:0] exp_d_q[$];
  int         exp_t_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic drive_ch();
    for (int i = 0; i < 8; i++) ch_values[i*8 +: 8] = m_ch[i];
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: address is taken only when no conversion is in progress.
  task automatic ale_pulse(input logic [2:0] a);
    ale  = 1'b1;
    addr = a;
    if (!m_busy) m_addr = a;
    tick(1);
    ale = 1'b0;
  endtask

  // A start rise discards any conversion still in flight.
  task automatic rise();
    start  = 1'b1;
    m_busy = 1'b1;
    if (exp_d_q.size() > 0) begin
      void'(exp_d_q.pop_back());
      void'(exp_t_q.pop_back());
    end
  endtask

  // Result equals the selected channel value at the fall; eoc rises S+8*BC+1 cycles later.
  task automatic fall();
    start = 1'b0;
    exp_d_q.push_back(m_ch[m_addr]);
    exp_t_q.push_back(int'($time / P) + S + 8 * BC + 1);
  endtask

  task automatic wait_done();
    tick(S + 8 * BC + 3);
    check("eoc_outstanding", 32'(exp_d_q.size()), 32'd0);
    exp_d_q.delete();
    exp_t_q.delete();
    m_busy = 1'b0;
  endtask

  task automatic convert(input logic [2:0] a);
    ale_pulse(a);
    tick(1);
    rise();
    tick(2);
    fall();
    wait_done();
  endtask

  // Monitor: every eoc rise must match the oldest expected result, on time.
  initial begin
    logic prev;
    logic [7:0] ed;
    int et;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && eoc && !prev) begin
        check("eoc_expected", 32'(exp_d_q.size() > 0), 32'd1);
        if (exp_d_q.size() > 0) begin
          ed = exp_d_q.pop_front();
          et = exp_t_q.pop_front();
          check("result_data", 32'(dout), 32'(ed));
          check("eoc_cycle", 32'(int'($time / P)), 32'(et));
          check("busy_at_eoc", 32'(busy), 32'd0);
        end
      end
      prev = eoc;
    end
  end

  initial begin
    #(P * 100000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] a;
    rst = 1'b1; ale = 1'b0; start = 1'b0; oe = 1'b0; addr = '0;
    for (int i = 0; i < 8; i++) m_ch[i] = 8'($urandom);
    drive_ch();
    m_addr = '0;
    m_busy = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_eoc", 32'(eoc), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_doe", 32'(doe), 32'd0);
    oe = 1'b1;
    tick(S + 1);
    check("rst_latch", 32'(dout), 32'd0);
    check("doe_on", 32'(doe), 32'd1);

    // Basic conversion of channel 3 with eoc/busy timing around the start rise.
    m_ch[3] = 8'hA7;
    drive_ch();
    ale_pulse(3'd3);
    tick(1);
    rise();
    tick(S);
    check("busy_before", 32'(busy), 32'd0);
    tick(1);
    check("busy_set", 32'(busy), 32'd1);
    tick(ED - 1);
    check("eoc_hold", 32'(eoc), 32'd1);
    tick(1);
    check("eoc_low", 32'(eoc), 32'd0);
    tick(2);
    fall();
    wait_done();
    check("ch3_dout", 32'(dout), 32'hA7);
    check("ch3_doe", 32'(doe), 32'd1);

    // Output enable gating without a new conversion.
    oe = 1'b0;
    tick(S + 1);
    check("oe_off_dout", 32'(dout), 32'd0);
    check("oe_off_doe", 32'(doe), 32'd0);
    oe = 1'b1;
    tick(S + 1);
    check("oe_back_dout", 32'(dout), 32'hA7);

    // Boundary values.
    m_ch[0] = 8'h00; m_ch[7] = 8'hFF; m_ch[5] = 8'h80;
    drive_ch();
    tick(1);
    convert(3'd0);
    convert(3'd7);
    convert(3'd5);

    // Restart 20 clocks into a conversion; only the new fall yields a result.
    m_ch[2] = 8'h3C;
    drive_ch();
    ale_pulse(3'd2);
    tick(1);
    rise();
    tick(2);
    fall();
    tick(20);
    rise();
    tick(S + 1);
    check("busy_abort", 32'(busy), 32'd1);
    check("eoc_abort", 32'(eoc), 32'd0);
    tick(2);
    fall();
    wait_done();

    // ALE while busy is ignored; channel change after the fall does not matter.
    m_ch[6] = 8'h5A;
    m_ch[2] = 8'h21;
    drive_ch();
    ale_pulse(3'd2);
    tick(1);
    rise();
    tick(2);
    fall();
    tick(10);
    m_ch[2] = 8'hDE;
    drive_ch();
    ale_pulse(3'd6);
    wait_done();
    check("ale_busy_dout", 32'(dout), 32'h21);
    convert(3'd6);
    check("ale_after_dout", 32'(dout), 32'h5A);

    // Reset 30 clocks into a conversion.
    m_ch[4] = 8'h99;
    drive_ch();
    ale_pulse(3'd4);
    tick(1);
    rise();
    tick(2);
    fall();
    tick(30);
    rst = 1'b1;
    exp_d_q.delete();
    exp_t_q.delete();
    m_busy = 1'b0;
    m_addr = '0;
    tick(1);
    check("midrst_eoc", 32'(eoc), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    tick(1);
    rst = 1'b0;
    start = 1'b0;
    tick(S + 1);
    check("midrst_stale", 32'(dout), 32'd0);

    // Single-cycle bit decisions on the fast instance.
    m_ch[4] = 8'h6B;
    drive_ch();
    ale_pulse(3'd4);
    tick(1);
    rise();
    tick(2);
    fall();
    tick(S + 8);
    check("fast_eoc_low", 32'(eoc1), 32'd0);
    tick(1);
    check("fast_eoc_high", 32'(eoc1), 32'd1);
    check("fast_dout", 32'(dout1), 32'h6B);
    wait_done();

    // Randomized conversions with optional ALE, busy ALE, channel changes and restarts.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 8; i++) m_ch[i] = 8'($urandom);
      drive_ch();
      a = 3'($urandom_range(7));
      if ($urandom_range(1) == 1) begin
        ale = 1'b1;
        addr = a;
        m_addr = a;
      end
      if ($urandom_range(1) == 1) tick(1);
      rise();
      tick($urandom_range(1, 4));
      ale = 1'b0;
      fall();
      tick($urandom_range(S + 2, 30));
      m_ch[$urandom_range(7)] = 8'($urandom);
      drive_ch();
      if ($urandom_range(1) == 1) ale_pulse(3'($urandom_range(7)));
      if ($urandom_range(3) == 0) begin
        tick($urandom_range(1, 10));
        rise();
        tick($urandom_range(1, 3));
        fall();
      end
      wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
